// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver with runtime-selectable framing.
//   clk          system clock (50 MHz), rising edge
//   arst         asynchronous reset, active high
//   rx           serial line, asynchronous, idle high
//   baud_rate    00=2400 01=4800 10=9600 11=19200
//   parity_type  00/11=none 01=odd 10=even
//   stop_bits    0=one 1=two
//   data_length  0=7 bits 1=8 bits
//   data_out     last received character (bit 7 = 0 in 7-bit mode)
//   rx_done      one-cycle pulse at frame completion
//   rx_active    high from start detection to end of frame
//   parity_error parity mismatch in last frame
//   frame_error  a stop bit sampled low in last frame
// The DIV_* parameters are the clk counts per 16x oversample tick.
module uart_rx #(
  parameter int DIV_2400  = 1302,
  parameter int DIV_4800  = 651,
  parameter int DIV_9600  = 326,
  parameter int DIV_19200 = 163
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       rx,
  input  logic [1:0] baud_rate,
  input  logic [1:0] parity_type,
  input  logic       stop_bits,
  input  logic       data_length,
  output logic [7:0] data_out,
  output logic       rx_done,
  output logic       rx_active,
  output logic       parity_error,
  output logic       frame_error
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

  state_t      state;
  logic        rx_s1, rxs;
  logic [1:0]  cfg_baud, cfg_par;
  logic        cfg_stop, cfg_len;
  logic [10:0] div_cnt, div_max;
  logic [3:0]  tick_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        par_acc, par_pend, fe_pend, stop_cnt, armed;
  logic        tick, samp, par_en, last_bit, fe_final;

  always_comb begin
    div_max = 11'(DIV_2400 - 1);
    case (cfg_baud)
      2'b01:   div_max = 11'(DIV_4800 - 1);
      2'b10:   div_max = 11'(DIV_9600 - 1);
      2'b11:   div_max = 11'(DIV_19200 - 1);
      default: div_max = 11'(DIV_2400 - 1);
    endcase
  end

  assign tick     = (div_cnt == div_max);
  // Start bit is checked at its centre (8 ticks); every later bit 16 ticks on.
  assign samp     = tick && (tick_cnt == ((state == START) ? 4'd7 : 4'd15));
  assign par_en   = (cfg_par == 2'b01) || (cfg_par == 2'b10);
  assign last_bit = (bit_cnt == (cfg_len ? 3'd7 : 3'd6));
  assign fe_final = fe_pend | ~rxs;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rx_s1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rxs   <= rx_s1;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state        <= IDLE;
      cfg_baud     <= 2'b00;
      cfg_par      <= 2'b00;
      cfg_stop     <= 1'b0;
      cfg_len      <= 1'b0;
      div_cnt      <= '0;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      par_acc      <= 1'b0;
      par_pend     <= 1'b0;
      fe_pend      <= 1'b0;
      stop_cnt     <= 1'b0;
      armed        <= 1'b1;
      data_out     <= 8'h00;
      rx_done      <= 1'b0;
      rx_active    <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      // Divider idles at 0, so it restarts exactly at start detection.
      if (state == IDLE || state == DONE) begin
        div_cnt  <= '0;
        tick_cnt <= '0;
      end else begin
        div_cnt <= tick ? 11'd0 : div_cnt + 11'd1;
        if (tick) tick_cnt <= samp ? 4'd0 : tick_cnt + 4'd1;
      end
      case (state)
        IDLE: begin
          // After a framing error (e.g. break) wait for the line to go idle.
          if (!armed) begin
            if (rxs) armed <= 1'b1;
          end else if (!rxs) begin
            state     <= START;
            rx_active <= 1'b1;
            cfg_baud  <= baud_rate;
            cfg_par   <= parity_type;
            cfg_stop  <= stop_bits;
            cfg_len   <= data_length;
            bit_cnt   <= '0;
            par_acc   <= 1'b0;
            par_pend  <= 1'b0;
            fe_pend   <= 1'b0;
            stop_cnt  <= 1'b0;
          end
        end
        START: if (samp) begin
          if (rxs) begin
            state     <= IDLE;
            rx_active <= 1'b0;
          end else begin
            state <= DATA;
          end
        end
        DATA: if (samp) begin
          shreg   <= {rxs, shreg[7:1]};
          par_acc <= par_acc ^ rxs;
          bit_cnt <= bit_cnt + 3'd1;
          if (last_bit) state <= par_en ? PARITY : STOP;
        end
        PARITY: if (samp) begin
          par_pend <= (cfg_par == 2'b01) ? ~(par_acc ^ rxs) : (par_acc ^ rxs);
          state    <= STOP;
        end
        STOP: if (samp) begin
          if (cfg_stop && !stop_cnt) begin
            stop_cnt <= 1'b1;
            fe_pend  <= fe_final;
          end else begin
            // Results land as DONE is entered so they are visible with rx_done.
            state        <= DONE;
            data_out     <= cfg_len ? shreg : {1'b0, shreg[7:1]};
            parity_error <= par_en & par_pend;
            frame_error  <= fe_final;
            rx_done      <= 1'b1;
            rx_active    <= 1'b0;
            armed        <= ~fe_final;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx. The main instance uses shortened
// dividers (32/16/8/4) to keep frames short; a second instance with the
// default dividers checks real start-centre timing at 9600 and 19200.
module tb_uart_rx;
  localparam int DV[4] = '{32, 16, 8, 4};

  logic       clk, arst, rx, rx_r;
  logic [1:0] baud_rate, parity_type, baud_r;
  logic       stop_bits, data_length;
  logic [7:0] data_out, data_out_r;
  logic       rx_done, rx_active, parity_error, frame_error;
  logic       rx_done_r, rx_active_r, parity_error_r, frame_error_r;

  int n_chk = 0, n_fail = 0;
  int ndone = 0, ndone_r = 0;
  logic [7:0] dlog [16];

  uart_rx #(.DIV_2400(32), .DIV_4800(16), .DIV_9600(8), .DIV_19200(4)) dut (
    .clk(clk), .arst(arst), .rx(rx), .baud_rate(baud_rate),
    .parity_type(parity_type), .stop_bits(stop_bits), .data_length(data_length),
    .data_out(data_out), .rx_done(rx_done), .rx_active(rx_active),
    .parity_error(parity_error), .frame_error(frame_error));

  uart_rx dut_r (
    .clk(clk), .arst(arst), .rx(rx_r), .baud_rate(baud_r),
    .parity_type(parity_type), .stop_bits(stop_bits), .data_length(data_length),
    .data_out(data_out_r), .rx_done(rx_done_r), .rx_active(rx_active_r),
    .parity_error(parity_error_r), .frame_error(frame_error_r));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(negedge clk) if (rx_done) begin
    ndone <= ndone + 1;
    dlog[ndone % 16] <= data_out;
  end
  always @(negedge clk) if (rx_done_r) ndone_r <= ndone_r + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // par < 0: no parity bit, else the parity bit level to send.
  // abort_at >= 0: reset the DUT just before that data bit and return.
  // scr: alter the config inputs mid-frame (receiver must ignore them).
  task automatic send(input logic [1:0] b, input logic [7:0] d, input int nbits,
                      input int par, input int nstop, input logic stop_lvl,
                      input int abort_at, input bit scr);
    int bt = 16 * DV[b];
    logic [1:0] sb = baud_rate, sp = parity_type;
    logic ss = stop_bits, sl = data_length;
    rx = 1'b0;
    wclk(bt);
    if (scr) begin
      baud_rate = ~baud_rate; parity_type = 2'b01;
      stop_bits = ~stop_bits; data_length = ~data_length;
    end
    for (int i = 0; i < nbits; i++) begin
      if (i == abort_at) begin
        chk("act_mid", rx_active, 1);
        arst = 1'b1;
        @(negedge clk);
        chk("rst_act", rx_active, 0);
        chk("rst_data", data_out, 8'h00);
        chk("rst_done", rx_done, 0);
        rx = 1'b1;
        wclk(4);
        arst = 1'b0;
        return;
      end
      rx = d[i];
      wclk(bt);
    end
    if (par >= 0) begin
      rx = par[0];
      wclk(bt);
    end
    for (int i = 0; i < nstop; i++) begin
      rx = stop_lvl;
      wclk(bt);
    end
    rx = 1'b1;
    baud_rate = sb; parity_type = sp; stop_bits = ss; data_length = sl;
  endtask

  initial begin
    int n0;
    arst = 1'b1; rx = 1'b1; rx_r = 1'b1; baud_r = 2'b10;
    baud_rate = 2'b10; parity_type = 2'b00; stop_bits = 1'b0; data_length = 1'b1;
    wclk(3);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_rx_done", rx_done, 0);
    chk("rst_rx_active", rx_active, 0);
    chk("rst_parity_err", parity_error, 0);
    chk("rst_frame_err", frame_error, 0);
    arst = 1'b0;
    wclk(4);

    // 9600 8N1 0xD5, config scrambled mid-frame
    n0 = ndone;
    send(2'b10, 8'hD5, 8, -1, 1, 1'b1, -1, 1'b1);
    wclk(100);
    chk("d5_done", ndone - n0, 1);
    chk("d5_data", data_out, 8'hD5);
    chk("d5_pe", parity_error, 0);
    chk("d5_fe", frame_error, 0);
    chk("d5_act", rx_active, 0);

    // 4800 7O2 0x55: parity 1 correct, parity 0 wrong
    baud_rate = 2'b01; data_length = 1'b0; parity_type = 2'b01; stop_bits = 1'b1;
    n0 = ndone;
    send(2'b01, 8'h55, 7, 1, 2, 1'b1, -1, 1'b0);
    wclk(100);
    chk("o55_done", ndone - n0, 1);
    chk("o55_data", data_out, 8'h55);
    chk("o55_pe", parity_error, 0);
    chk("o55_fe", frame_error, 0);
    send(2'b01, 8'h55, 7, 0, 2, 1'b1, -1, 1'b0);
    wclk(100);
    chk("o55b_done", ndone - n0, 2);
    chk("o55b_data", data_out, 8'h55);
    chk("o55b_pe", parity_error, 1);

    // 19200 8E1 0xA3, stop bit low
    baud_rate = 2'b11; data_length = 1'b1; parity_type = 2'b10; stop_bits = 1'b0;
    n0 = ndone;
    send(2'b11, 8'hA3, 8, 0, 1, 1'b0, -1, 1'b0);
    wclk(100);
    chk("a3_done", ndone - n0, 1);
    chk("a3_data", data_out, 8'hA3);
    chk("a3_fe", frame_error, 1);
    chk("a3_pe", parity_error, 0);

    // break at 19200 8N1: one frame, then wait for idle line
    parity_type = 2'b00;
    n0 = ndone;
    rx = 1'b0;
    wclk(20 * 64);
    chk("brk_done", ndone - n0, 1);
    chk("brk_fe", frame_error, 1);
    chk("brk_data", data_out, 8'h00);
    chk("brk_act", rx_active, 0);
    rx = 1'b1;
    wclk(128);
    send(2'b11, 8'h5A, 8, -1, 1, 1'b1, -1, 1'b0);
    wclk(50);
    chk("5a_done", ndone - n0, 2);
    chk("5a_data", data_out, 8'h5A);
    chk("5a_fe", frame_error, 0);

    // 9600 glitch on the scaled instance
    baud_rate = 2'b10;
    n0 = ndone;
    rx = 1'b0; wclk(3); rx = 1'b1;
    wclk(300);
    chk("gl_done", ndone - n0, 0);
    chk("gl_act", rx_active, 0);

    // real dividers: false start resolves at the start-bit centre
    baud_r = 2'b10;
    rx_r = 1'b0; wclk(3); rx_r = 1'b1;
    wclk(7);
    chk("r96_act_early", rx_active_r, 1);
    wclk(2580);
    chk("r96_act_pre", rx_active_r, 1);
    wclk(35);
    chk("r96_act_post", rx_active_r, 0);
    baud_r = 2'b11;
    wclk(20);
    rx_r = 1'b0; wclk(3); rx_r = 1'b1;
    wclk(1287);
    chk("r192_act_pre", rx_active_r, 1);
    wclk(30);
    chk("r192_act_post", rx_active_r, 0);
    chk("r_done", ndone_r, 0);

    // 2400 8N1: reset mid-data, then 0x3C
    baud_rate = 2'b00; data_length = 1'b1; parity_type = 2'b00; stop_bits = 1'b0;
    n0 = ndone;
    send(2'b00, 8'h77, 8, -1, 1, 1'b1, 3, 1'b0);
    wclk(1024);
    chk("rst_nodone", ndone - n0, 0);
    send(2'b00, 8'h3C, 8, -1, 1, 1'b1, -1, 1'b0);
    wclk(200);
    chk("3c_done", ndone - n0, 1);
    chk("3c_data", data_out, 8'h3C);

    // 19200 8N2 back-to-back 0x01, 0xFF
    baud_rate = 2'b11; stop_bits = 1'b1;
    n0 = ndone;
    send(2'b11, 8'h01, 8, -1, 2, 1'b1, -1, 1'b0);
    send(2'b11, 8'hFF, 8, -1, 2, 1'b1, -1, 1'b0);
    wclk(50);
    chk("b2b_done", ndone - n0, 2);
    chk("b2b_first", dlog[n0 % 16], 8'h01);
    chk("b2b_second", dlog[(n0 + 1) % 16], 8'hFF);
    chk("b2b_data", data_out, 8'hFF);
    chk("b2b_fe", frame_error, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
